mdr_ctrl: RTL and testbench

Sequencing controller for the multiply/divide/square-root (MDR) iterative datapath. It accepts one operation request at a time through a start/ready handshake. It drives the enable and synchronous-clear strobes of the datapath's operand, accumulator and shift registers, counts iterations, and reports completion or a divide-by-zero / illegal-opcode error. It sits between the MDR top-level request interface and the register/ALU datapath.

---
 rtl/mdr_pkg.sv | 28 ++
 rtl/mdr_iter_cnt.sv | 28 ++
 rtl/mdr_ctrl.sv | 119 +++++++++++
 tb/tb_mdr_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types, widths and the iteration-count helper for the MDR controller.
package mdr_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        DIV    = 2'b01,
        SQRT   = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    // Number of datapath iterations for an opcode; square root retires two bits per step.
    function automatic int unsigned iter_n(op_e op);
        return (op == SQRT) ? (DW / 2) : DW;
    endfunction

endpackage

// File: rtl/mdr_iter_cnt.sv
// Iteration counter with synchronous clear and terminal-count compare.
module mdr_iter_cnt
    import mdr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          sync_rst,
    input  logic [CW-1:0] tc,
    output logic [CW-1:0] iter_cnt,
    output logic          last
);

    // Count up while enabled; synchronous clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt <= '0;
        end else if (sync_rst) begin
            iter_cnt <= '0;
        end else if (enb) begin
            iter_cnt <= iter_cnt + CW'(1);
        end
    end

    // Terminal count reached on the current index.
    assign last = (iter_cnt == tc);

endmodule

// File: rtl/mdr_ctrl.sv
// Sequencing FSM for the iterative multiply/divide/square-root datapath.
module mdr_ctrl
    import mdr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          divisor_zero,
    output logic          ready,
    output logic          busy,
    output logic [1:0]    op_sel,
    output logic          load_enb,
    output logic          acc_enb,
    output logic          acc_clr,
    output logic          step_enb,
    output logic [CW-1:0] iter_cnt,
    output logic          done,
    output logic          error
);

    state_e        state_q;
    state_e        state_d;
    logic          ready_d;
    logic          load_enb_d;
    logic          acc_enb_d;
    logic          acc_clr_d;
    logic          step_enb_d;
    logic          done_d;
    logic          error_d;
    logic          cnt_last;
    logic          cnt_enb;
    logic          cnt_sync_rst;
    logic [CW-1:0] cnt_tc;

    assign cnt_enb      = (state_q == RUN);
    assign cnt_sync_rst = (state_q == CLEAR) || ((state_q == RUN) && cnt_last);
    assign cnt_tc       = CW'(iter_n(op_e'(op_sel)) - 1);

    mdr_iter_cnt u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .enb      (cnt_enb),
        .sync_rst (cnt_sync_rst),
        .tc       (cnt_tc),
        .iter_cnt (iter_cnt),
        .last     (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore decode of the upcoming state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  state_d = CLEAR;
            CLEAR: begin
                if ((op_sel == OP_ILL) || ((op_sel == DIV) && divisor_zero)) begin
                    state_d = ERR;
                end else begin
                    state_d = RUN;
                end
            end
            RUN:   if (cnt_last) state_d = DONE;
            DONE:  state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d    = (state_d == IDLE);
        load_enb_d = (state_d == LOAD);
        acc_clr_d  = (state_d == CLEAR);
        acc_enb_d  = (state_d == CLEAR) || (state_d == RUN);
        step_enb_d = (state_d == RUN);
        done_d     = (state_d == DONE) || (state_d == ERR);
        error_d    = (state_d == ERR);
    end

    // Output registers; values track the state register one-for-one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready    <= 1'b1;
            busy     <= 1'b0;
            load_enb <= 1'b0;
            acc_enb  <= 1'b0;
            acc_clr  <= 1'b0;
            step_enb <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            ready    <= ready_d;
            busy     <= !ready_d;
            load_enb <= load_enb_d;
            acc_enb  <= acc_enb_d;
            acc_clr  <= acc_clr_d;
            step_enb <= step_enb_d;
            done     <= done_d;
            error    <= error_d;
        end
    end

    // Opcode latch; only written on an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_sel <= 2'b00;
        end else if ((state_q == IDLE) && start) begin
            op_sel <= op;
        end
    end

endmodule

// File: tb/tb_mdr_ctrl.sv
// Directed, table-driven bench for the MDR sequencing controller.
module tb_mdr_ctrl;
    import mdr_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic          divisor_zero;
    logic          ready;
    logic          busy;
    logic [1:0]    op_sel;
    logic          load_enb;
    logic          acc_enb;
    logic          acc_clr;
    logic          step_enb;
    logic [CW-1:0] iter_cnt;
    logic          done;
    logic          error;

    int checks   = 0;
    int failures = 0;

    mdr_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .divisor_zero (divisor_zero),
        .ready        (ready),
        .busy         (busy),
        .op_sel       (op_sel),
        .load_enb     (load_enb),
        .acc_enb      (acc_enb),
        .acc_clr      (acc_clr),
        .step_enb     (step_enb),
        .iter_cnt     (iter_cnt),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic       dz;
        int         stray;
        int         steps;
        int         done_e;
        int         err;
        int         rdy_e;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // All outputs packed: ready,busy,op_sel,iter_cnt,load,acc_enb,acc_clr,step,done,error.
    function automatic int pack_outs();
        return int'({ready, busy, op_sel, iter_cnt, load_enb, acc_enb, acc_clr, step_enb, done, error});
    endfunction

    // Expected reset image: ready=1, all else 0.
    function automatic int reset_image();
        logic [CW+9:0] img;
        img = '0;
        img[CW+9] = 1'b1;
        return int'(img);
    endfunction

    // Issue one request and observe edges E0.. until ready returns (bounded).
    task automatic run_op(input logic [1:0] o, input logic dz, input int stray,
                          output int steps, output int done_e, output int err_cnt,
                          output int done_cnt, output int rdy_e, output int loads,
                          output int clrs, output int seq_bad);
        steps = 0; done_e = -1; err_cnt = 0; done_cnt = 0; rdy_e = -1;
        loads = 0; clrs = 0; seq_bad = 0;
        @(negedge clk);
        start = 1'b1;
        op = o;
        divisor_zero = dz;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            start = (stray > 0) && (k + 1 == stray);
            op = ~o;
            if (load_enb) loads++;
            if (acc_clr) begin
                clrs++;
                if (!acc_enb) seq_bad++;
            end
            if (step_enb) begin
                if (iter_cnt != CW'(steps)) seq_bad++;
                if (!acc_enb) seq_bad++;
                steps++;
            end
            if (op_sel != o) seq_bad++;
            if (busy == ready) seq_bad++;
            if (done) begin
                done_cnt++;
                if (done_e < 0) done_e = k;
                if (iter_cnt != '0) seq_bad++;
            end
            if (error) begin
                err_cnt++;
                if (!done) seq_bad++;
            end
            if (ready && done_e < 0) seq_bad++;
            if (ready && done_e >= 0 && k > done_e && rdy_e < 0) rdy_e = k;
            if (rdy_e >= 0) break;
        end
        start = 1'b0;
        op = o;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int steps, done_e, err_cnt, done_cnt, rdy_e, loads, clrs, seq_bad;
        run_op(v.op, v.dz, v.stray, steps, done_e, err_cnt, done_cnt, rdy_e, loads, clrs, seq_bad);
        chk({tag, " steps"}, steps, v.steps);
        chk({tag, " done_edge"}, done_e, v.done_e);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " error_count"}, err_cnt, v.err);
        chk({tag, " ready_edge"}, rdy_e, v.rdy_e);
        chk({tag, " load_cycles"}, loads, 1);
        chk({tag, " clear_cycles"}, clrs, 1);
        chk({tag, " sequence"}, seq_bad, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int guard;

        // op, dz, stray start edge, steps, done edge, error count, ready edge
        vecs[0] = '{2'b00, 1'b0, 0, 16, 18, 0, 19};
        vecs[1] = '{2'b10, 1'b0, 0,  8, 10, 0, 11};
        vecs[2] = '{2'b01, 1'b0, 0, 16, 18, 0, 19};
        vecs[3] = '{2'b01, 1'b1, 0,  0,  2, 1,  3};
        vecs[4] = '{2'b11, 1'b0, 0,  0,  2, 1,  3};
        vecs[5] = '{2'b00, 1'b0, 8, 16, 18, 0, 19};
        vecs[6] = '{2'b00, 1'b1, 0, 16, 18, 0, 19};

        start = 1'b0;
        op = 2'b00;
        divisor_zero = 1'b0;
        rst = 1'b0;
        #12;
        chk("reset_outputs", pack_outs(), reset_image());
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of a DIV at iteration 7.
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        divisor_zero = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(step_enb && iter_cnt == CW'(7)) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("midrun_reached_iter7", int'(step_enb && iter_cnt == CW'(7)), 1);
        rst = 1'b0;
        #1;
        chk("midrun_reset_outputs", pack_outs(), reset_image());
        @(posedge clk);
        #1;
        chk("midrun_reset_held", pack_outs(), reset_image());
        @(negedge clk);
        rst = 1'b1;
        run_vec("post_reset_mul", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
